// File: rtl/ds_decim_16_if.sv
// rtl/ds_decim_16_if.sv - decoded-sample valid/ready stream between decimator and consumer
interface ds_decim_16_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/ds_decim_16.sv
// rtl/ds_decim_16.sv - first-order delta-sigma integrate-and-dump decimator, signed output word
module ds_decim_16 #(
  parameter int DECIM = 256,
  parameter int OUT_W = 16,
  parameter int CNT_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              bit_en,
  input  logic              bit_in,
  ds_decim_16_if.master     dout_if,
  output logic              overrun
);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] ones_final;
  logic [OUT_W-1:0] result;
  logic             win_end;
  logic             slot_free;

  assign win_end    = bit_en && (win_cnt == CNT_W'(DECIM - 1));
  assign ones_final = ones + {{(CNT_W-1){1'b0}}, bit_in};

  // Each one is +1 and each zero is -1: ones - (DECIM - ones) = 2*ones - DECIM.
  assign result    = (OUT_W'(ones_final) << 1) - OUT_W'(DECIM);
  assign slot_free = !dout_if.dout_valid || dout_if.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt            <= '0;
      ones               <= '0;
      dout_if.dout       <= '0;
      dout_if.dout_valid <= 1'b0;
      overrun            <= 1'b0;
    end else if (clr) begin
      win_cnt            <= '0;
      ones               <= '0;
      dout_if.dout_valid <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (win_end) begin
        win_cnt <= '0;
        ones    <= '0;
      end else if (bit_en) begin
        win_cnt <= win_cnt + 1'b1;
        ones    <= ones_final;
      end

      // A word accepted this cycle frees the slot for a result finishing on the same edge.
      if (win_end) begin
        if (slot_free) begin
          dout_if.dout       <= result;
          dout_if.dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_if.dout_valid && dout_if.dout_ready) begin
        dout_if.dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds_decim_16.sv
// tb/tb_ds_decim_16.sv - scoreboard bench for ds_decim_16 with DECIM=8
module tb_ds_decim_16;

  localparam int DECIM = 8;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic bit_en;
  logic bit_in;
  logic overrun;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  ds_decim_16_if #(.OUT_W(OUT_W)) dif ();

  ds_decim_16 #(.DECIM(DECIM), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bit_en  (bit_en),
    .bit_in  (bit_in),
    .dout_if (dif.master),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Accepted words are matched in order against what the stimulus predicted.
  always @(negedge clk) begin
    if (rst_n && dif.dout_valid && dif.dout_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", {16'h0, dif.dout}, 32'hFFFF_FFFF);
      end else begin
        check("sb_word", {16'h0, dif.dout}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input int gap);
    bit_en = 1'b1;
    bit_in = b;
    step();
    bit_en = 1'b0;
    repeat (gap) step();
  endtask

  function automatic logic [15:0] expect_word(input logic [7:0] bits);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(bits[i]);
    return 16'(2 * n - DECIM);
  endfunction

  task automatic window(input logic [7:0] bits, input int gap, input bit kept);
    if (kept) sb_q.push_back(expect_word(bits));
    for (int i = 0; i < 8; i++) send(bits[i], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bit_en = 1'b0;
    bit_in = 1'b0;
    dif.dout_ready = 1'b1;
    #12;
    check("reset_dout", {16'h0, dif.dout}, 32'h0);
    check("reset_valid", {31'h0, dif.dout_valid}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // all ones: +8, valid for exactly one cycle
    window(8'hFF, 0, 1'b1);
    check("ones_valid", {31'h0, dif.dout_valid}, 32'h1);
    check("ones_dout", {16'h0, dif.dout}, 32'h0008);
    step();
    check("ones_valid_drop", {31'h0, dif.dout_valid}, 32'h0);

    window(8'h00, 0, 1'b1);
    check("zeros_dout", {16'h0, dif.dout}, 32'hFFF8);
    step();
    window(8'b0101_0101, 0, 1'b1);
    check("alt_dout", {16'h0, dif.dout}, 32'h0000);
    step();

    // six ones, two zeros, idle gaps between enabled samples
    sb_q.push_back(16'd4);
    for (int i = 0; i < 7; i++) send(i < 6, 2);
    check("gap_no_early", {31'h0, dif.dout_valid}, 32'h0);
    send(1'b0, 0);
    check("gap_valid", {31'h0, dif.dout_valid}, 32'h1);
    check("gap_dout", {16'h0, dif.dout}, 32'h0004);
    step();

    // backpressure across two windows: first held, second dropped
    dif.dout_ready = 1'b0;
    window(8'b0000_0111, 0, 1'b1);
    window(8'hFF, 0, 1'b0);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    check("ovr_valid", {31'h0, dif.dout_valid}, 32'h1);
    check("ovr_held", {16'h0, dif.dout}, 32'hFFFE);
    dif.dout_ready = 1'b1;
    step();
    check("ovr_accepted", {31'h0, dif.dout_valid}, 32'h0);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_overrun", {31'h0, overrun}, 32'h0);
    check("clr_dout_kept", {16'h0, dif.dout}, 32'hFFFE);

    // ready exactly on window-end edge with a pending word
    dif.dout_ready = 1'b0;
    window(8'hFF, 0, 1'b1);
    sb_q.push_back(16'd2);
    for (int i = 0; i < 7; i++) send(i < 5, 0);
    dif.dout_ready = 1'b1;
    send(1'b0, 0);
    check("sim_valid", {31'h0, dif.dout_valid}, 32'h1);
    check("sim_dout", {16'h0, dif.dout}, 32'h0002);
    check("sim_overrun", {31'h0, overrun}, 32'h0);
    step();
    check("sim_drained", {31'h0, dif.dout_valid}, 32'h0);

    // clr mid-window discards the partial count
    for (int i = 0; i < 3; i++) send(1'b1, 0);
    clr = 1'b1;
    bit_en = 1'b1;
    bit_in = 1'b1;
    step();
    clr = 1'b0;
    bit_en = 1'b0;
    check("clr_valid", {31'h0, dif.dout_valid}, 32'h0);
    window(8'b0000_0001, 0, 1'b1);
    check("clr_fresh_dout", {16'h0, dif.dout}, 32'hFFFA);
    step();

    // async reset mid-window
    for (int i = 0; i < 5; i++) send(1'b1, 0);
    rst_n = 1'b0;
    #2;
    check("arst_dout", {16'h0, dif.dout}, 32'h0);
    check("arst_valid", {31'h0, dif.dout_valid}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    window(8'hFF, 0, 1'b1);
    check("arst_fresh_dout", {16'h0, dif.dout}, 32'h0008);
    step();
    step();

    check("sb_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
